// File: rtl/instruction_ram_loader.sv
// Loads a byte-stream program image into instruction RAM one 32-bit word per write, holding the CPU meanwhile.
// mem_write one cycle after a word's 4th byte; byte_ready low outside header/data phases, so the source holds bytes.
module instruction_ram_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERROR
  } state_t;

  state_t              state;
  logic [15:0]         count;
  logic [23:0]         assembly;
  logic [1:0]          byte_idx;
  logic                xfer;
  logic [15:0]         header;
  logic [ADDR_WIDTH:0] next_word;

  assign xfer      = byte_valid & byte_ready;
  assign header    = {count[15:8], byte_in};
  assign next_word = words_loaded + {{ADDR_WIDTH{1'b0}}, 1'b1};

  // words_loaded doubles as the write index: it always equals the next RAM address.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      assembly     <= '0;
      byte_idx     <= '0;
      byte_ready   <= 1'b0;
      mem_write    <= 1'b0;
      mem_address  <= '0;
      mem_data     <= '0;
      cpu_hold     <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state        <= HDR_HI;
            byte_ready   <= 1'b1;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
          end
        end
        HDR_HI: begin
          if (xfer) begin
            count <= {byte_in, 8'h00};
            state <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (xfer) begin
            count    <= header;
            byte_idx <= '0;
            if (header == 16'd0) begin
              state      <= DONE;
              byte_ready <= 1'b0;
              load_done  <= 1'b1;
              cpu_hold   <= 1'b0;
            end else if (header > 16'(DEPTH)) begin
              state      <= ERROR;
              byte_ready <= 1'b0;
              load_error <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            assembly <= {assembly[15:0], byte_in};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state       <= WRITE;
              byte_ready  <= 1'b0;
              mem_write   <= 1'b1;
              mem_address <= words_loaded[ADDR_WIDTH-1:0];
              mem_data    <= {assembly, byte_in};
            end
          end
        end
        WRITE: begin
          mem_write    <= 1'b0;
          words_loaded <= next_word;
          if (16'(next_word) == count) begin
            state     <= DONE;
            load_done <= 1'b1;
            cpu_hold  <= 1'b0;
          end else begin
            state      <= DATA;
            byte_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
